// File: rtl/fl_vadd_sched.sv
`default_nettype none
// ============================================================================
// Module   : fl_vadd_sched
// Brief    : Job controller for the FP vector-add pipeline. AXI-lite programs the job,
//            START launches both readers and the writer, irq is raised when all three finish.
//            Optional watchdog: define FL_VADD_SCHED_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module fl_vadd_sched #(
  parameter int AXI_PS_ADDR_WIDTH  = 5,
  parameter int AXI_PS_DATAWIDTH   = 32,
  parameter int AXI_DDR_ADDR_WIDTH = 32,
  parameter int LEN_WIDTH          = 16,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [AXI_PS_ADDR_WIDTH-1:0]  waddr,
  input  logic                          wavalid,
  output logic                          waready,
  input  logic [AXI_PS_DATAWIDTH-1:0]   wdata,
  input  logic                          wvalid,
  output logic                          wready,
  output logic                          wresp,
  output logic                          bvalid,
  input  logic                          bready,
  output logic                          x_start,
  output logic                          y_start,
  output logic                          o_start,
  output logic [AXI_DDR_ADDR_WIDTH-1:0] x_base,
  output logic [AXI_DDR_ADDR_WIDTH-1:0] y_base,
  output logic [AXI_DDR_ADDR_WIDTH-1:0] o_base,
  output logic [LEN_WIDTH-1:0]          len,
  input  logic                          x_done,
  input  logic                          y_done,
  input  logic                          o_done,
  output logic                          busy,
  output logic                          irq,
  output logic                          err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [AXI_PS_ADDR_WIDTH-1:0] A_CTRL = AXI_PS_ADDR_WIDTH'(32'h00);
  localparam logic [AXI_PS_ADDR_WIDTH-1:0] A_LEN  = AXI_PS_ADDR_WIDTH'(32'h04);
  localparam logic [AXI_PS_ADDR_WIDTH-1:0] A_XB   = AXI_PS_ADDR_WIDTH'(32'h08);
  localparam logic [AXI_PS_ADDR_WIDTH-1:0] A_YB   = AXI_PS_ADDR_WIDTH'(32'h0C);
  localparam logic [AXI_PS_ADDR_WIDTH-1:0] A_OB   = AXI_PS_ADDR_WIDTH'(32'h10);

  logic [1:0]                    state_q, state_d;
  logic [2:0]                    flags_q, flags_d;
  logic                          irq_q, irq_d;
  logic                          bvalid_q, bvalid_d;
  logic                          wresp_q, wresp_d;
  logic [LEN_WIDTH-1:0]          len_q;
  logic [AXI_DDR_ADDR_WIDTH-1:0] xb_q, yb_q, ob_q;

  logic       w_accept, w_busy, w_hit_ctrl, w_hit_reg;
  logic       w_start, w_clr, w_reg_wr, w_reject, w_all;
  logic [2:0] w_done;

  assign w_accept   = wavalid & wvalid & ~bvalid_q;
  assign waready    = w_accept;
  assign wready     = w_accept;
  assign w_busy     = (state_q == S_LAUNCH) || (state_q == S_RUN);
  assign w_hit_ctrl = (waddr == A_CTRL);
  assign w_hit_reg  = (waddr == A_LEN) || (waddr == A_XB) || (waddr == A_YB) || (waddr == A_OB);
  assign w_start    = w_accept & w_hit_ctrl & wdata[0] & ~w_busy;
  assign w_clr      = w_accept & w_hit_ctrl & wdata[1];
  assign w_reg_wr   = w_accept & w_hit_reg & ~w_busy;
  assign w_reject   = ~(w_hit_ctrl | w_hit_reg) | (w_busy & (w_hit_reg | (w_hit_ctrl & wdata[0])));
  assign w_done     = {o_done, y_done, x_done};
  // A strobe in the current cycle counts towards completion.
  assign w_all      = &(flags_q | w_done);

`ifdef FL_VADD_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          err_q;
  logic          w_timeout;

  assign w_timeout = (state_q == S_RUN) && !w_all && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == S_LAUNCH)   cnt_q <= '0;
      else if (state_q == S_RUN) cnt_q <= cnt_q + 1'b1;
      if (w_timeout)             err_q <= 1'b1;
      else if (w_start)          err_q <= 1'b0;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (w_start)               state_d = (len_q != '0) ? S_LAUNCH : S_DONE;
        else if (state_q == S_DONE) state_d = S_IDLE;
      end
      S_LAUNCH: begin
        flags_d = w_done;
        state_d = S_RUN;
      end
      S_RUN: begin
        flags_d = flags_q | w_done;
        if (w_all) state_d = S_DONE;
`ifdef FL_VADD_SCHED_TIMEOUT_EN
        else if (w_timeout) state_d = S_DONE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    x_start = (state_q == S_LAUNCH);
    y_start = (state_q == S_LAUNCH);
    o_start = (state_q == S_LAUNCH);
    busy    = w_busy;
  end

  // Completion beats a simultaneous IRQ_CLR.
  always_comb begin
    irq_d    = irq_q;
    bvalid_d = bvalid_q;
    wresp_d  = wresp_q;
    if (state_d == S_DONE) irq_d = 1'b1;
    else if (w_clr)        irq_d = 1'b0;
    if (w_accept) begin
      bvalid_d = 1'b1;
      wresp_d  = w_reject;
    end else if (bready) begin
      bvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q  <= '0;
      irq_q    <= 1'b0;
      bvalid_q <= 1'b0;
      wresp_q  <= 1'b0;
      len_q    <= '0;
      xb_q     <= '0;
      yb_q     <= '0;
      ob_q     <= '0;
    end else begin
      flags_q  <= flags_d;
      irq_q    <= irq_d;
      bvalid_q <= bvalid_d;
      wresp_q  <= wresp_d;
      if (w_reg_wr) begin
        case (waddr)
          A_LEN:   len_q <= LEN_WIDTH'(wdata);
          A_XB:    xb_q  <= AXI_DDR_ADDR_WIDTH'(wdata);
          A_YB:    yb_q  <= AXI_DDR_ADDR_WIDTH'(wdata);
          A_OB:    ob_q  <= AXI_DDR_ADDR_WIDTH'(wdata);
          default: ;
        endcase
      end
    end
  end

  assign bvalid = bvalid_q;
  assign wresp  = wresp_q;
  assign irq    = irq_q;
  assign len    = len_q;
  assign x_base = xb_q;
  assign y_base = yb_q;
  assign o_base = ob_q;

endmodule
`default_nettype wire
